// File: rtl/multi_sync_cell.sv
// multi_sync_cell
//   Carries WIDTH independent asynchronous single-bit levels into the clk
//   domain through a STAGES-deep flop chain, an optional per-bit stability
//   filter, and registered rise/fall edge pulses.
//
// Ports
//   clk   : sole clock
//   rstn  : asynchronous, active-low reset
//   d     : asynchronous inputs, one independent signal per bit
//   o     : synchronised (and filtered) level
//   rise  : one-cycle pulse when o[i] goes 0->1
//   fall  : one-cycle pulse when o[i] goes 1->0
//   chg   : registered OR of all rise/fall bits
module multi_sync_cell #(
    parameter int unsigned      WIDTH      = 4,
    parameter int unsigned      STAGES     = 2,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter int unsigned      FILTER_LEN = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             chg
);

    if (STAGES < 2) begin : g_bad_stages
        $error("multi_sync_cell: STAGES must be at least 2");
    end
    if (FILTER_LEN > 255) begin : g_bad_filter
        $error("multi_sync_cell: FILTER_LEN must not exceed 255");
    end

    logic [WIDTH-1:0] r_chain [STAGES];
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_o_next;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_chg;

    // Pure flop chain: no logic between stages.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_chain[k] <= RST_VAL;
            end
        end else begin
            r_chain[0] <= d;
            for (int unsigned k = 1; k < STAGES; k++) begin
                r_chain[k] <= r_chain[k-1];
            end
        end
    end

    assign w_s = r_chain[STAGES-1];

    if (FILTER_LEN == 0) begin : g_no_filter
        // o is the last chain stage; its next value is the stage before it,
        // which lets the edge pulses register in the same cycle o changes.
        assign o        = w_s;
        assign w_o_next = r_chain[STAGES-2];
    end else begin : g_filter
        localparam int unsigned    CW       = $clog2(FILTER_LEN + 1);
        localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

        logic [CW-1:0]    r_cnt      [WIDTH];
        logic [CW-1:0]    w_cnt_next [WIDTH];
        logic [WIDTH-1:0] r_o;

        // Counter tracks consecutive edges on which s differs from o; any
        // agreement restarts it, reaching the last count commits the change.
        always_comb begin
            w_o_next = r_o;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                w_cnt_next[i] = '0;
                if (w_s[i] != r_o[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        w_o_next[i] = w_s[i];
                    end else begin
                        w_cnt_next[i] = r_cnt[i] + 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_o <= RST_VAL;
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    r_cnt[i] <= '0;
                end
            end else begin
                r_o <= w_o_next;
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    r_cnt[i] <= w_cnt_next[i];
                end
            end
        end

        assign o = r_o;
    end

    // Pulses come from next vs current o so they align with the new level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rise <= '0;
            r_fall <= '0;
            r_chg  <= 1'b0;
        end else begin
            r_rise <= w_o_next & ~o;
            r_fall <= ~w_o_next & o;
            r_chg  <= |(w_o_next ^ o);
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
    assign chg  = r_chg;

endmodule

// File: tb/tb_multi_sync_cell.sv
module tb_multi_sync_cell;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn_a, rstn_b, rstn_c;
    logic [3:0] d_a, d_b, d_c;
    logic [3:0] o_a, o_b, o_c;
    logic [3:0] rise_a, rise_b, rise_c;
    logic [3:0] fall_a, fall_b, fall_c;
    logic       chg_a, chg_b, chg_c;

    multi_sync_cell #(.WIDTH(4), .STAGES(3), .RST_VAL(4'b0101), .FILTER_LEN(0)) u_a (
        .clk(clk), .rstn(rstn_a), .d(d_a), .o(o_a),
        .rise(rise_a), .fall(fall_a), .chg(chg_a)
    );
    multi_sync_cell #(.WIDTH(4), .STAGES(2), .RST_VAL(4'b0000), .FILTER_LEN(4)) u_b (
        .clk(clk), .rstn(rstn_b), .d(d_b), .o(o_b),
        .rise(rise_b), .fall(fall_b), .chg(chg_b)
    );
    multi_sync_cell #(.WIDTH(4), .STAGES(2), .RST_VAL(4'b0000), .FILTER_LEN(8)) u_c (
        .clk(clk), .rstn(rstn_c), .d(d_c), .o(o_c),
        .rise(rise_c), .fall(fall_c), .chg(chg_c)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: s after edge n is d sampled STAGES-1 edges earlier;
    // o flips once s has disagreed with it on FILTER_LEN consecutive edges.
    int         cfg_s  [3] = '{3, 2, 2};
    int         cfg_f  [3] = '{0, 4, 8};
    logic [3:0] cfg_rv [3] = '{4'b0101, 4'b0000, 4'b0000};

    int         m_n    [3];
    logic [3:0] m_dh   [3][16];
    logic [3:0] m_o    [3];
    logic [3:0] m_rise [3];
    logic [3:0] m_fall [3];
    logic       m_chg  [3];
    int         m_run  [3][4];

    function automatic logic [3:0] s_after(input int k, input int n);
        int idx;
        idx = n - cfg_s[k] + 1;
        if (idx < 0) return cfg_rv[k];
        return m_dh[k][idx % 16];
    endfunction

    task automatic m_reset(input int k);
        m_n[k]    = 0;
        m_o[k]    = cfg_rv[k];
        m_rise[k] = '0;
        m_fall[k] = '0;
        m_chg[k]  = 1'b0;
        for (int b = 0; b < 4; b++) m_run[k][b] = 0;
    endtask

    task automatic m_step(input int k, input logic [3:0] dv);
        logic [3:0] sp, sn, on;
        int n;
        n = m_n[k];
        m_dh[k][n % 16] = dv;
        sp = s_after(k, n - 1);
        sn = s_after(k, n);
        on = m_o[k];
        if (cfg_f[k] == 0) begin
            on = sn;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (sp[b] != m_o[k][b]) m_run[k][b] = m_run[k][b] + 1;
                else                    m_run[k][b] = 0;
                if (m_run[k][b] == cfg_f[k]) begin
                    on[b] = sp[b];
                    m_run[k][b] = 0;
                end
            end
        end
        m_rise[k] = on & ~m_o[k];
        m_fall[k] = ~on & m_o[k];
        m_chg[k]  = |(on ^ m_o[k]);
        m_o[k]    = on;
        m_n[k]    = n + 1;
    endtask

    int         pulses [3];
    int         trans  [3];
    logic [3:0] prev_o [3];

    task automatic cmp_model(input int k, input logic [3:0] ov, input logic [3:0] rv,
                             input logic [3:0] fv, input logic cv);
        check($sformatf("rnd%0d_o", k), ov, m_o[k]);
        check($sformatf("rnd%0d_rise", k), rv, m_rise[k]);
        check($sformatf("rnd%0d_fall", k), fv, m_fall[k]);
        check($sformatf("rnd%0d_chg", k), cv, m_chg[k]);
        check($sformatf("rnd%0d_rise_fall_overlap", k), rv & fv, 0);
        pulses[k] += $countones(rv | fv);
        trans[k]  += $countones(ov ^ prev_o[k]);
        prev_o[k] = ov;
    endtask

    typedef struct {
        logic [3:0] d;
        logic [3:0] o;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       chg;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Instance A: STAGES=3, no filter, o follows d two rows later.
        tbl[0]  = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0001, 4'b0101, 4'b0000, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0001, 4'b0101, 4'b0000, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0101, 4'b0001, 4'b0000, 4'b0100, 1'b1};
        tbl[4]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0};
        tbl[5]  = '{4'b1001, 4'b0101, 4'b0100, 4'b0000, 1'b1};
        tbl[6]  = '{4'b0110, 4'b0000, 4'b0000, 4'b0101, 1'b1};
        tbl[7]  = '{4'b1111, 4'b1001, 4'b1001, 4'b0000, 1'b1};
        tbl[8]  = '{4'b1111, 4'b0110, 4'b0110, 4'b1001, 1'b1};
        tbl[9]  = '{4'b1111, 4'b1111, 4'b1001, 4'b0000, 1'b1};
        tbl[10] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0};

        // Reset behaviour
        rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;
        d_a = 4'b0101; d_b = 4'b0000; d_c = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_a", o_a, 4'b0101);
        check("rst_pulse_a", {rise_a, fall_a, chg_a}, 0);
        check("rst_o_bc", {o_b, o_c}, 0);
        @(negedge clk);
        rstn_a = 1'b1; rstn_b = 1'b1; rstn_c = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            check("rel_o_a", o_a, 4'b0101);
            check("rel_pulse_a", {rise_a, fall_a, chg_a}, 0);
            check("rel_pulse_bc", {rise_b, fall_b, chg_b, rise_c, fall_c, chg_c}, 0);
        end

        // Table-driven vectors on instance A
        for (int i = 0; i < 11; i++) begin
            d_a = tbl[i].d;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_o", i), o_a, tbl[i].o);
            check($sformatf("tbl%0d_rise", i), rise_a, tbl[i].rise);
            check($sformatf("tbl%0d_fall", i), fall_a, tbl[i].fall);
            check($sformatf("tbl%0d_chg", i), chg_a, tbl[i].chg);
        end

        // Asynchronous reset takes effect without a clock edge
        rstn_a = 1'b0;
        #2;
        check("async_rst_o_a", o_a, 4'b0101);
        check("async_rst_pulse_a", {rise_a, fall_a, chg_a}, 0);
        @(negedge clk);
        d_a = 4'b0101;
        rstn_a = 1'b1;

        // Instance B (F=4): 3-cycle glitch is discarded
        for (int e = 1; e <= 12; e++) begin
            d_b = (e <= 3) ? 4'b0001 : 4'b0000;
            @(posedge clk);
            #1;
            check("glitch_o_b", o_b, 4'b0000);
            check("glitch_pulse_b", {rise_b, fall_b, chg_b}, 0);
        end

        // Instance B: 4-cycle pulse passes, fall four cycles after s drops
        for (int e = 1; e <= 14; e++) begin
            d_b = (e <= 4) ? 4'b0001 : 4'b0000;
            @(posedge clk);
            #1;
            check($sformatf("pulse_o_b_e%0d", e), o_b, (e >= 6 && e < 10) ? 4'b0001 : 4'b0000);
            check($sformatf("pulse_rise_b_e%0d", e), rise_b, (e == 6) ? 4'b0001 : 4'b0000);
            check($sformatf("pulse_fall_b_e%0d", e), fall_b, (e == 10) ? 4'b0001 : 4'b0000);
            check($sformatf("pulse_chg_b_e%0d", e), chg_b, (e == 6 || e == 10) ? 1'b1 : 1'b0);
        end

        // Instance C (F=8): reset five cycles after s[1] rises
        for (int e = 1; e <= 7; e++) begin
            d_c = 4'b0010;
            @(posedge clk);
            #1;
            check("midflt_pre_o_c", o_c, 4'b0000);
        end
        rstn_c = 1'b0;
        #1;
        check("midflt_rst_o_c", o_c, 4'b0000);
        check("midflt_rst_pulse_c", {rise_c, fall_c, chg_c}, 0);
        repeat (2) @(posedge clk);
        #1;
        check("midflt_hold_o_c", o_c, 4'b0000);
        @(negedge clk);
        rstn_c = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("midflt_o_c_e%0d", e), o_c, (e >= 10) ? 4'b0010 : 4'b0000);
            check($sformatf("midflt_rise_c_e%0d", e), rise_c, (e == 10) ? 4'b0010 : 4'b0000);
            check($sformatf("midflt_fall_c_e%0d", e), fall_c, 4'b0000);
        end

        // Randomised run against the reference model
        rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;
        d_a = 4'b0101; d_b = 4'b0000; d_c = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            m_reset(k);
            pulses[k] = 0;
            trans[k]  = 0;
            prev_o[k] = cfg_rv[k];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn_a = 1'b1; rstn_b = 1'b1; rstn_c = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 1) == 0)  d_a[b] = ~d_a[b];
                if ($urandom_range(0, 7) == 0)  d_b[b] = ~d_b[b];
                if ($urandom_range(0, 15) == 0) d_c[b] = ~d_c[b];
            end
            @(posedge clk);
            m_step(0, d_a);
            m_step(1, d_b);
            m_step(2, d_c);
            #1;
            cmp_model(0, o_a, rise_a, fall_a, chg_a);
            cmp_model(1, o_b, rise_b, fall_b, chg_b);
            cmp_model(2, o_c, rise_c, fall_c, chg_c);
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rnd%0d_pulse_count", k), pulses[k], trans[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
